des_decryption: RTL and testbench

DES_DECRYPTION -- requirements
Module: des_decryption

---
 rtl/des_pkg.sv | 91 +++++++++
 rtl/des_f.sv | 24 ++
 rtl/des_decryption.sv | 105 ++++++++++
 tb/tb_des_decryption.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES definitions: permutation and S-box tables, FSM state encoding and
// the table-driven helper functions used by the Feistel datapath.
package des_pkg;

    localparam int NUM_ROUNDS = 16;
    localparam int SUBKEY_W   = 48;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } des_state_e;

    // Tables use DES bit numbering: entry n names input bit n, bit 1 being the MSB.
    localparam logic [6:0] IP_T [64] = '{
        7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,  7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
        7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,  7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
        7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,  7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7};

    localparam logic [6:0] FP_T [64] = '{
        7'd40, 7'd8, 7'd48, 7'd16, 7'd56, 7'd24, 7'd64, 7'd32, 7'd39, 7'd7, 7'd47, 7'd15, 7'd55, 7'd23, 7'd63, 7'd31,
        7'd38, 7'd6, 7'd46, 7'd14, 7'd54, 7'd22, 7'd62, 7'd30, 7'd37, 7'd5, 7'd45, 7'd13, 7'd53, 7'd21, 7'd61, 7'd29,
        7'd36, 7'd4, 7'd44, 7'd12, 7'd52, 7'd20, 7'd60, 7'd28, 7'd35, 7'd3, 7'd43, 7'd11, 7'd51, 7'd19, 7'd59, 7'd27,
        7'd34, 7'd2, 7'd42, 7'd10, 7'd50, 7'd18, 7'd58, 7'd26, 7'd33, 7'd1, 7'd41, 7'd9,  7'd49, 7'd17, 7'd57, 7'd25};

    localparam logic [5:0] E_T [48] = '{
        6'd32, 6'd1,  6'd2,  6'd3,  6'd4,  6'd5,  6'd4,  6'd5,  6'd6,  6'd7,  6'd8,  6'd9,
        6'd8,  6'd9,  6'd10, 6'd11, 6'd12, 6'd13, 6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17,
        6'd16, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21, 6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd25,
        6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29, 6'd28, 6'd29, 6'd30, 6'd31, 6'd32, 6'd1};

    localparam logic [5:0] P_T [32] = '{
        6'd16, 6'd7, 6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17, 6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
        6'd2,  6'd8, 6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,  6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25};

    // Each S-box packs its 4x16 entries row-major, entry 0 in the top nibble.
    localparam logic [255:0] S_BOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        y = 64'd0;
        for (int i = 0; i < 64; i++) begin
            y[63 - i] = x[6'(7'd64 - IP_T[i])];
        end
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        y = 64'd0;
        for (int i = 0; i < 64; i++) begin
            y[63 - i] = x[6'(7'd64 - FP_T[i])];
        end
        return y;
    endfunction

    function automatic logic [47:0] e_expand(input logic [31:0] x);
        logic [47:0] y;
        y = 48'd0;
        for (int i = 0; i < 48; i++) begin
            y[47 - i] = x[5'(6'd32 - E_T[i])];
        end
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        y = 32'd0;
        for (int i = 0; i < 32; i++) begin
            y[31 - i] = x[5'(6'd32 - P_T[i])];
        end
        return y;
    endfunction

    // Outer bits select the row, inner four bits the column.
    function automatic logic [3:0] sbox(input logic [2:0] n, input logic [5:0] b);
        logic [255:0] t;
        t = S_BOX[n] << {b[5], b[0], b[4:1], 2'b00};
        return t[255:252];
    endfunction

endpackage

// File: rtl/des_f.sv
// DES Feistel function: expand R, mix in the subkey, substitute through the
// eight S-boxes and apply the P permutation.
module des_f
    import des_pkg::*;
(
    input  logic [31:0]         r_i,
    input  logic [SUBKEY_W-1:0] k_i,
    output logic [31:0]         f_o
);

    logic [47:0] x_s;
    logic [31:0] s_s;

    // One full f(R, K) evaluation per cycle.
    always_comb begin
        x_s = e_expand(r_i) ^ k_i;
        s_s = 32'd0;
        for (int i = 0; i < 8; i++) begin
            s_s[31 - 4*i -: 4] = sbox(3'(i), x_s[47 - 6*i -: 6]);
        end
        f_o = p_perm(s_s);
    end

endmodule

// File: rtl/des_decryption.sv
// Iterative DES decryption core: one Feistel round per clock, subkeys applied
// K16 first, plaintext registered and flagged with a single-cycle done pulse.
module des_decryption
    import des_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start_i,
    input  logic [63:0]                     ciphertext_i,
    input  logic [NUM_ROUNDS*SUBKEY_W-1:0]  round_keys_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic [63:0]                     result_o
);

    des_state_e          state_q;
    logic [3:0]          cnt_q;
    logic [31:0]         l_q;
    logic [31:0]         r_q;
    logic [31:0]         l_d;
    logic [31:0]         r_d;
    logic [31:0]         f_s;
    logic [63:0]         ip_s;
    logic [SUBKEY_W-1:0] keys_q [NUM_ROUNDS];
    logic [SUBKEY_W-1:0] subkey_s;
    logic                busy_q;
    logic                done_q;
    logic [63:0]         result_q;

    // keys_q[c] holds K(16-c), so the round counter walks the schedule backwards.
    assign subkey_s = keys_q[cnt_q];

    des_f u_f (
        .r_i (r_q),
        .k_i (subkey_s),
        .f_o (f_s)
    );

    // Initial permutation of the incoming block and next Feistel half-blocks.
    always_comb begin
        ip_s = ip_perm(ciphertext_i);
        l_d  = r_q;
        r_d  = l_q ^ f_s;
    end

    // Control FSM with the round datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            l_q      <= 32'd0;
            r_q      <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 64'd0;
            for (int i = 0; i < NUM_ROUNDS; i++) begin
                keys_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q    <= ST_ROUND;
                        busy_q     <= 1'b1;
                        cnt_q      <= 4'd0;
                        {l_q, r_q} <= ip_s;
                        for (int i = 0; i < NUM_ROUNDS; i++) begin
                            keys_q[i] <= round_keys_i[i*SUBKEY_W +: SUBKEY_W];
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_ROUND: begin
                    l_q <= l_d;
                    r_q <= r_d;
                    // Last round: halves swap back before the final permutation.
                    if (cnt_q == 4'(NUM_ROUNDS - 1)) begin
                        state_q  <= ST_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= fp_perm({r_d, l_d});
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_des_decryption.sv
// Directed and random checks of des_decryption against a standalone DES
// reference model (key schedule plus encryption) built from the FIPS tables.
module tb_des_decryption;

    logic         clk;
    logic         rst;
    logic         start;
    logic [63:0]  ct;
    logic [767:0] rk;
    logic         busy;
    logic         done;
    logic [63:0]  result;

    int           n_checks;
    int           n_errors;
    logic [63:0]  prev_res;

    des_decryption dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .ciphertext_i (ct),
        .round_keys_i (rk),
        .busy_o       (busy),
        .done_o       (done),
        .result_o     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int IP_T [64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                      57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
    int FP_T [64] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
                      36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
    int E_T [48]  = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                      16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
    int P_T [32]  = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    int PC1_T [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                       63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    int PC2_T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                       41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    int SB [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8, 4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5, 0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1, 13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9, 10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6, 4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8, 9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6, 1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2, 7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    // Generic DES permutation: output bit i is input bit T[i] of a win-bit word (bit 1 = MSB).
    function automatic logic [63:0] perm(input logic [63:0] x, input int win, input int n, input int sel);
        logic [63:0] y;
        int src;
        y = 64'd0;
        for (int i = 0; i < n; i++) begin
            case (sel)
                0: src = IP_T[i];
                1: src = FP_T[i];
                2: src = E_T[i];
                3: src = P_T[i];
                4: src = PC1_T[i];
                default: src = PC2_T[i];
            endcase
            y = {y[62:0], x[win - src]};
        end
        return y;
    endfunction

    function automatic logic [31:0] model_f(input logic [31:0] r, input logic [47:0] k);
        logic [63:0] e;
        logic [63:0] p;
        logic [31:0] s;
        int six;
        int row;
        int col;
        e = perm({32'd0, r}, 32, 48, 2) ^ {16'd0, k};
        s = 32'd0;
        for (int i = 0; i < 8; i++) begin
            six = int'(e[47 - 6*i -: 6]);
            row = (six / 32) * 2 + (six % 2);
            col = (six / 2) % 16;
            s = {s[27:0], 4'(SB[i][row*16 + col])};
        end
        p = perm({32'd0, s}, 32, 32, 3);
        return p[31:0];
    endfunction

    // Key schedule packed as the core expects: K1 in the top 48 bits, K16 at the bottom.
    function automatic logic [767:0] sched(input logic [63:0] key);
        logic [63:0]  cd;
        logic [63:0]  t;
        logic [27:0]  c;
        logic [27:0]  d;
        logic [767:0] ks;
        cd = perm(key, 64, 56, 4);
        c  = cd[55:28];
        d  = cd[27:0];
        ks = '0;
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < SHIFTS[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            t  = perm({8'd0, c, d}, 56, 48, 5);
            ks = {ks[719:0], t[47:0]};
        end
        return ks;
    endfunction

    function automatic logic [63:0] des_enc(input logic [63:0] pt, input logic [767:0] ks);
        logic [63:0] x;
        logic [31:0] l;
        logic [31:0] r;
        logic [31:0] t;
        x = perm(pt, 64, 64, 0);
        l = x[63:32];
        r = x[31:0];
        for (int i = 1; i <= 16; i++) begin
            t = r;
            r = l ^ model_f(r, ks[768 - 48*i +: 48]);
            l = t;
        end
        return perm({r, l}, 64, 64, 1);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Rounds N+1..N+16 after acceptance, then the cycle after the done pulse.
    task automatic finish_rounds(input logic [63:0] exp, input bit inv, input string tag);
        int early;
        early = 0;
        for (int k = 1; k <= 16; k++) begin
            if (inv) begin
                ct = ~ct;
                rk = ~rk;
            end
            tick();
            if (k < 16 && done) early++;
            if (k == 8) begin
                check({tag, "_busy_mid"}, {63'd0, busy}, 64'd1);
                check({tag, "_result_hold"}, result, prev_res);
            end
        end
        check({tag, "_early_done"}, 64'(early), 64'd0);
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        check({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
        check({tag, "_result"}, result, exp);
        prev_res = exp;
        tick();
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    endtask

    task automatic run_op(input logic [63:0] c, input logic [767:0] k, input logic [63:0] exp,
                          input bit inv, input string tag);
        ct    = c;
        rk    = k;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy_accept"}, {63'd0, busy}, 64'd1);
        finish_rounds(exp, inv, tag);
    endtask

    logic [767:0] rk_std;
    logic [63:0]  key;
    logic [63:0]  pt;
    int           nd;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        start    = 1'b0;
        ct       = 64'd0;
        rk       = '0;
        prev_res = 64'd0;
        repeat (2) tick();
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_result", result, 64'd0);
        rst = 1'b0;

        rk_std = sched(64'h133457799BBCDFF1);
        check("model_k1", {16'd0, rk_std[767:720]}, 64'h0000_1B02EFFC7072);
        check("model_k16", {16'd0, rk_std[47:0]}, 64'h0000_CB3D8B0E17F5);
        check("model_enc", des_enc(64'h0123456789ABCDEF, rk_std), 64'h85E813540F0AB405);

        run_op(64'h8CA64DE9C1B123A7, '0, 64'h0000000000000000, 1'b0, "zero_key");
        run_op(64'h85E813540F0AB405, rk_std, 64'h0123456789ABCDEF, 1'b0, "std");
        run_op(64'h85E813540F0AB405, rk_std, 64'h0123456789ABCDEF, 1'b1, "stable");

        // Start held through the whole operation: exactly one done, next accept at N+18.
        ct    = 64'h85E813540F0AB405;
        rk    = rk_std;
        start = 1'b1;
        tick();
        check("held_busy_accept", {63'd0, busy}, 64'd1);
        nd = 0;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (done) nd++;
            if (k == 16) check("held_result", result, 64'h0123456789ABCDEF);
            if (k == 17) check("held_ignored_in_done", {63'd0, busy}, 64'd0);
        end
        prev_res = 64'h0123456789ABCDEF;
        check("held_one_done", 64'(nd), 64'd1);
        ct = 64'h8CA64DE9C1B123A7;
        rk = '0;
        tick();
        start = 1'b0;
        check("held_reaccept", {63'd0, busy}, 64'd1);
        finish_rounds(64'd0, 1'b0, "held_second");

        // Asynchronous reset after round 8: everything clears at once, no done follows.
        ct    = 64'h85E813540F0AB405;
        rk    = rk_std;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        #3;
        rst = 1'b1;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_result", result, 64'd0);
        #2;
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done || busy) nd++;
        end
        check("abort_quiet", 64'(nd), 64'd0);
        prev_res = 64'd0;
        run_op(64'h8CA64DE9C1B123A7, '0, 64'd0, 1'b0, "after_abort");
        run_op(64'h85E813540F0AB405, rk_std, 64'h0123456789ABCDEF, 1'b0, "after_abort_std");

        // Round trip against the reference encryption.
        for (int n = 0; n < 100; n++) begin
            key = {$urandom, $urandom};
            pt  = {$urandom, $urandom};
            rk_std = sched(key);
            run_op(des_enc(pt, rk_std), rk_std, pt, 1'(n % 7 == 3), "roundtrip");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
